// File: rtl/rob_multi_port.sv
// Reorder buffer: in-order allocate, out-of-order completion on NUM_WB write-back channels,
// in-order retire of up to COMMIT_W entries per cycle. Define ROB_PERF_CNT_EN for perf counters.
module rob_multi_port #(
  parameter int DEPTH_BIT = 4,
  parameter int NUM_WB    = 2,
  parameter int COMMIT_W  = 2
) (
  input  logic                          clk_in,
  input  logic                          rst_n_in,
  input  logic                          rdy_in,
  input  logic                          alloc_valid,
  input  logic                          alloc_done,
  input  logic [31:0]                   alloc_val,
  input  logic [4:0]                    alloc_rd,
  input  logic [1:0]                    alloc_type,
  input  logic [31:0]                   alloc_pred_pc,
  output logic                          alloc_full,
  output logic [DEPTH_BIT-1:0]          alloc_tag,
  input  logic [NUM_WB-1:0]             wb_valid,
  input  logic [NUM_WB*DEPTH_BIT-1:0]   wb_tag,
  input  logic [NUM_WB*32-1:0]          wb_val,
  input  logic [2*DEPTH_BIT-1:0]        q_tag,
  output logic [1:0]                    q_ready,
  output logic [63:0]                   q_val,
  output logic [COMMIT_W-1:0]           cm_valid,
  output logic [COMMIT_W*5-1:0]         cm_rd,
  output logic [COMMIT_W*32-1:0]        cm_val,
  output logic [COMMIT_W*DEPTH_BIT-1:0] cm_tag,
  output logic [DEPTH_BIT-1:0]          head_tag,
  output logic                          head_is_mem,
  output logic                          flush,
  output logic [31:0]                   flush_pc
`ifdef ROB_PERF_CNT_EN
  ,
  output logic [31:0]                   perf_commits,
  output logic [31:0]                   perf_mispred
`endif
);
  localparam int DEPTH = 1 << DEPTH_BIT;

  typedef enum logic [1:0] {TY_RD = 2'd0, TY_ST = 2'd1, TY_BR = 2'd2, TY_LD = 2'd3} rob_type_e;
  typedef logic [DEPTH_BIT-1:0] tag_t;

  logic [DEPTH-1:0] busy_q, done_q;
  logic [31:0]      val_q  [DEPTH];
  logic [31:0]      pred_q [DEPTH];
  logic [4:0]       rd_q   [DEPTH];
  rob_type_e        type_q [DEPTH];
  tag_t             head_q, tail_q;
  logic [DEPTH_BIT:0] count_q;
  logic             flush_q;
  logic [31:0]      flush_pc_q;

  logic               active, alloc_acc, chain, mispred;
  logic [31:0]        mispred_pc;
  logic [DEPTH_BIT:0] n_ret;
  logic [COMMIT_W-1:0] slot_ret;
  tag_t               slot_idx [COMMIT_W];
  tag_t               q_idx    [2];

  // A pending flush owns the cycle: nothing allocates, completes or retires.
  assign active      = rdy_in & ~flush_q;
  assign alloc_full  = (count_q == (DEPTH_BIT+1)'(DEPTH));
  assign alloc_acc   = active & alloc_valid & ~alloc_full;
  assign alloc_tag   = tail_q;
  assign head_tag    = head_q;
  assign head_is_mem = busy_q[head_q] & (type_q[head_q] == TY_ST || type_q[head_q] == TY_LD);
  assign flush       = flush_q;
  assign flush_pc    = flush_pc_q;
  assign cm_valid    = slot_ret;

  always_comb begin
    // NOTE: combinational blocks use blocking '=' so 'chain' and 'n_ret' ripple slot to slot.
    chain      = active;
    n_ret      = '0;
    mispred    = 1'b0;
    mispred_pc = '0;
    slot_ret   = '0;
    cm_rd      = '0;
    cm_val     = '0;
    cm_tag     = '0;
    for (int s = 0; s < COMMIT_W; s++) begin
      slot_idx[s] = head_q + tag_t'(s);
      if (chain && busy_q[slot_idx[s]] && done_q[slot_idx[s]] &&
          (s == 0 || (type_q[slot_idx[s]] != TY_ST && type_q[slot_idx[s]] != TY_BR))) begin
        slot_ret[s]                       = 1'b1;
        n_ret                             = n_ret + (DEPTH_BIT+1)'(1);
        cm_tag[s*DEPTH_BIT +: DEPTH_BIT]  = slot_idx[s];
        cm_val[s*32 +: 32]                = val_q[slot_idx[s]];
        cm_rd[s*5 +: 5]                   = (type_q[slot_idx[s]] == TY_ST ||
                                             type_q[slot_idx[s]] == TY_BR) ? 5'd0 : rd_q[slot_idx[s]];
        chain                             = (type_q[slot_idx[s]] != TY_BR);
        if (type_q[slot_idx[s]] == TY_BR && val_q[slot_idx[s]] != pred_q[slot_idx[s]]) begin
          mispred    = 1'b1;
          mispred_pc = val_q[slot_idx[s]];
        end
      end else begin
        chain = 1'b0;
      end
    end
  end

  // Operand lookup: stored result beats same-cycle write-back, which beats the allocating entry.
  always_comb begin
    q_ready = '0;
    q_val   = '0;
    for (int p = 0; p < 2; p++) begin
      q_idx[p] = q_tag[p*DEPTH_BIT +: DEPTH_BIT];
      if (alloc_acc && alloc_done && q_idx[p] == tail_q) begin
        q_ready[p]       = 1'b1;
        q_val[p*32 +: 32] = alloc_val;
      end
      for (int k = 0; k < NUM_WB; k++) begin
        if (wb_valid[k] && busy_q[q_idx[p]] && wb_tag[k*DEPTH_BIT +: DEPTH_BIT] == q_idx[p]) begin
          q_ready[p]       = 1'b1;
          q_val[p*32 +: 32] = wb_val[k*32 +: 32];
        end
      end
      if (done_q[q_idx[p]]) begin
        q_ready[p]       = 1'b1;
        q_val[p*32 +: 32] = val_q[q_idx[p]];
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      busy_q     <= '0;
      done_q     <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      flush_q    <= 1'b0;
      flush_pc_q <= '0;
    end else if (rdy_in) begin
      if (flush_q) begin
        busy_q  <= '0;
        done_q  <= '0;
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
        flush_q <= 1'b0;
      end else begin
        for (int k = 0; k < NUM_WB; k++)
          if (wb_valid[k] && busy_q[wb_tag[k*DEPTH_BIT +: DEPTH_BIT]])
            done_q[wb_tag[k*DEPTH_BIT +: DEPTH_BIT]] <= 1'b1;
        for (int s = 0; s < COMMIT_W; s++)
          if (slot_ret[s]) begin
            busy_q[slot_idx[s]] <= 1'b0;
            done_q[slot_idx[s]] <= 1'b0;
          end
        if (alloc_acc) begin
          busy_q[tail_q] <= 1'b1;
          done_q[tail_q] <= alloc_done;
        end
        head_q  <= head_q + n_ret[DEPTH_BIT-1:0];
        tail_q  <= tail_q + tag_t'(alloc_acc);
        count_q <= count_q + (DEPTH_BIT+1)'(alloc_acc) - n_ret;
        if (mispred) begin
          flush_q    <= 1'b1;
          flush_pc_q <= mispred_pc;
        end
      end
    end
  end

  // NOTE: payload arrays carry no reset; busy/done qualify every read of them.
  always_ff @(posedge clk_in) begin
    if (rst_n_in && active) begin
      for (int k = 0; k < NUM_WB; k++)
        if (wb_valid[k] && busy_q[wb_tag[k*DEPTH_BIT +: DEPTH_BIT]])
          val_q[wb_tag[k*DEPTH_BIT +: DEPTH_BIT]] <= wb_val[k*32 +: 32];
      if (alloc_acc) begin
        val_q[tail_q]  <= alloc_val;
        rd_q[tail_q]   <= alloc_rd;
        type_q[tail_q] <= rob_type_e'(alloc_type);
        pred_q[tail_q] <= alloc_pred_pc;
      end
    end
  end

`ifdef ROB_PERF_CNT_EN
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      perf_commits <= '0;
      perf_mispred <= '0;
    end else if (rdy_in) begin
      perf_commits <= perf_commits + 32'(n_ret);
      if (flush_q) perf_mispred <= perf_mispred + 32'd1;
    end
  end
`endif

endmodule
